uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit sequencer; serialises one frame per accepted request, bit period from baud divisor table.
//  Sits between host/register logic and the TX pin.
//  Owns baud-select sampling: a new baud code applies only between frames, never mid-frame.
//  Frame = start, 7/8 data bits LSB first, optional parity, 1 stop bit.
// PARAMETERS
//  DIV_W      19  width of bit-period divisor (fits 333_333)
//  SIM_DIV     0  if nonzero, every baud code uses this divisor (sim acceleration); 0 = table
// PORTS
//  clk       in   1      system clock, 100 MHz; sole clock
//  reset     in   1      synchronous, active-high
//  baud      in   4      baud select code, sampled only in IDLE
//  eight     in   1      1 = 8 data bits, 0 = 7 (tx_data[7] ignored)
//  pen       in   1      parity enable
//  ohel      in   1      parity sense: 1 = odd, 0 = even
//  tx_start  in   1      one-cycle request; accepted only when tx_rdy = 1
//  tx_data   in   8      frame payload, captured on acceptance
//  tx        out  1      serial line, idle high
//  tx_rdy    out  1      1 = IDLE, ready for tx_start
//  tx_done   out  1      one-cycle pulse as a frame's stop bit completes
//  tx_ovr    out  1      one-cycle pulse when tx_start arrives while tx_rdy = 0
// BEHAVIOUR
//  Reset: tx=1, tx_rdy=1, tx_done=0, tx_ovr=0, state IDLE, bit counter 0, baud_q=0.
//  Reset mid-frame aborts: tx=1 the next edge, no tx_done.
//  Divisor k (baud_q): 0:333_333 1:83_333 2:41_667 3:20_833 4:10_417 5:5_208 6:2_604 7:1_736
//   8:868 9:434 A:217 B:109; codes C-F -> 333_333.
//  IDLE: baud_q <= baud every cycle. tx_start=1 -> capture tx_data/eight/pen/ohel, compute parity,
//   clear bit timer, go START; tx_rdy=0 and tx=0 from the next edge (1-cycle latency).
//  States IDLE -> START -> DATA -> [PARITY if pen_q] -> STOP -> IDLE.
//  Bit timer: counts 0..k-1 per bit; bit_end when count==k-1; wraps to 0, advances state/bit index.
//   Every bit is exactly k clocks; count, k compared at DIV_W bits, no truncation.
//  DATA: index 0..6 (eight_q=0) or 0..7; tx = shift register LSB; shift on bit_end.
//  Parity = XOR of sent data bits, inverted when ohel_q=1 (odd -> total ones incl. parity odd).
//  STOP: tx=1; on bit_end tx_done=1 for one cycle, state IDLE, tx_rdy=1 same edge.
//  Frame length: 9+pen+eight bits x k cycles; tx_rdy low for exactly that many cycles.
//  Back-to-back: tx_start on the first tx_rdy=1 cycle -> start bit the next cycle; no extra gap.
//  tx_start with tx_rdy=0: ignored, frame undisturbed, tx_ovr pulses 1 cycle.
//  baud/eight/pen/ohel changes while busy have no effect until the next IDLE sample/capture.
//  All outputs registered; no combinational input-to-output path.
// STRUCTURE
//  Include uart_defs.vh: state encodings, baud-code localparams, divisor table as localparams.
//  Sub-module uart_bit_timer (clk, reset, clr, k[DIV_W-1:0] -> bit_end): free counter with clear.
//  Top holds FSM, shift register, bit index, parity, baud_q and the divisor lookup (with SIM_DIV).
// TESTING
//  baud=B, eight=1, pen=0, tx_data=A5, start -> tx 0,1,0,1,0,0,1,0,1,1 each 109 clk;
//   tx_rdy low 1090 clk; tx_done pulse at cycle 1090 after the start edge.
//  baud=B, eight=1, pen=1, ohel=0, data=03 -> parity 0; ohel=1 -> parity 1; 11 bits, 1199 clk.
//  eight=0, pen=1, ohel=0, data=80 -> 7 data bits 0000000, parity 0; bit7 never sent; 10 bits.
//  Start at baud=B, change baud to A after 200 clk -> rest of frame at 109; next frame at 217/bit.
//  tx_start pulsed mid-frame -> tx_ovr one pulse, frame unchanged; back-to-back start on tx_rdy -> no gap.
//  reset asserted at DATA bit 3 -> tx=1, tx_rdy=1 next edge, no tx_done; baud=F -> bit period 333_333.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types, baud codes and divisor table for the UART transmit sequencer.
// Divisors are bit periods in 100 MHz clocks; codes C-F fall back to the slowest rate.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  typedef struct packed {
    logic eight;
    logic pen;
    logic ohel;
  } fmt_t;

  localparam int TBL_W = 19;

  localparam logic [3:0] BAUD_300    = 4'h0;
  localparam logic [3:0] BAUD_1200   = 4'h1;
  localparam logic [3:0] BAUD_2400   = 4'h2;
  localparam logic [3:0] BAUD_4800   = 4'h3;
  localparam logic [3:0] BAUD_9600   = 4'h4;
  localparam logic [3:0] BAUD_19200  = 4'h5;
  localparam logic [3:0] BAUD_38400  = 4'h6;
  localparam logic [3:0] BAUD_57600  = 4'h7;
  localparam logic [3:0] BAUD_115200 = 4'h8;
  localparam logic [3:0] BAUD_230400 = 4'h9;
  localparam logic [3:0] BAUD_460800 = 4'hA;
  localparam logic [3:0] BAUD_921600 = 4'hB;

  localparam logic [TBL_W-1:0] DIV_300    = 19'd333_333;
  localparam logic [TBL_W-1:0] DIV_1200   = 19'd83_333;
  localparam logic [TBL_W-1:0] DIV_2400   = 19'd41_667;
  localparam logic [TBL_W-1:0] DIV_4800   = 19'd20_833;
  localparam logic [TBL_W-1:0] DIV_9600   = 19'd10_417;
  localparam logic [TBL_W-1:0] DIV_19200  = 19'd5_208;
  localparam logic [TBL_W-1:0] DIV_38400  = 19'd2_604;
  localparam logic [TBL_W-1:0] DIV_57600  = 19'd1_736;
  localparam logic [TBL_W-1:0] DIV_115200 = 19'd868;
  localparam logic [TBL_W-1:0] DIV_230400 = 19'd434;
  localparam logic [TBL_W-1:0] DIV_460800 = 19'd217;
  localparam logic [TBL_W-1:0] DIV_921600 = 19'd109;

  function automatic logic [TBL_W-1:0] baud_div(input logic [3:0] code);
    logic [TBL_W-1:0] d;
    case (code)
      BAUD_300:    d = DIV_300;
      BAUD_1200:   d = DIV_1200;
      BAUD_2400:   d = DIV_2400;
      BAUD_4800:   d = DIV_4800;
      BAUD_9600:   d = DIV_9600;
      BAUD_19200:  d = DIV_19200;
      BAUD_38400:  d = DIV_38400;
      BAUD_57600:  d = DIV_57600;
      BAUD_115200: d = DIV_115200;
      BAUD_230400: d = DIV_230400;
      BAUD_460800: d = DIV_460800;
      BAUD_921600: d = DIV_921600;
      default:     d = DIV_300;
    endcase
    return d;
  endfunction

  // Bit 7 only counts in 8-bit frames; odd sense inverts the even parity.
  function automatic logic calc_parity(input logic [7:0] data, input fmt_t fmt);
    logic [7:0] mask;
    mask = fmt.eight ? 8'hFF : 8'h7F;
    return (^(data & mask)) ^ fmt.ohel;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// Bit-period counter: counts 0..k-1, bit_end is high during the last count of each period.
// Latency: bit_end valid the same cycle count reaches k-1; no backpressure, clr holds it at zero.
module uart_bit_timer #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] k,
  output logic             bit_end
);

  logic [DIV_W-1:0] count;

  assign bit_end = (count == (k - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (bit_end) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 7/8 data LSB first, optional parity, one stop bit.
// Line drops one cycle after acceptance; requests while busy are dropped and flagged on tx_ovr.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DIV_W   = 19,
  parameter int SIM_DIV = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_rdy,
  output logic       tx_done,
  output logic       tx_ovr
);

  state_t           state, state_n;
  logic [3:0]       baud_q;
  fmt_t             fmt_q, fmt_in;
  logic             par_q;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       idx, idx_n, last_idx;
  logic             tx_n, done_n, accept;
  logic [DIV_W-1:0] k;
  logic             bit_end;

  assign fmt_in   = '{eight: eight, pen: pen, ohel: ohel};
  assign last_idx = fmt_q.eight ? 3'd7 : 3'd6;

  always_comb begin
    if (SIM_DIV != 0) begin
      k = DIV_W'(SIM_DIV);
    end else begin
      k = DIV_W'(baud_div(baud_q));
    end
  end

  // Held in clear while idle so the start bit always gets a full k cycles.
  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == ST_IDLE),
    .k       (k),
    .bit_end (bit_end)
  );

  // tx_n is the line value for the cycle after the edge, so tx stays registered.
  always_comb begin
    state_n = state;
    tx_n    = 1'b1;
    done_n  = 1'b0;
    shreg_n = shreg;
    idx_n   = idx;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          state_n = ST_START;
          tx_n    = 1'b0;
          shreg_n = tx_data;
          idx_n   = 3'd0;
        end
      end
      ST_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        tx_n = shreg[0];
        if (bit_end) begin
          shreg_n = {1'b0, shreg[7:1]};
          if (idx == last_idx) begin
            idx_n = 3'd0;
            if (fmt_q.pen) begin
              state_n = ST_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        tx_n = par_q;
        if (bit_end) begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      tx_rdy  <= 1'b1;
      tx_done <= 1'b0;
      tx_ovr  <= 1'b0;
      shreg   <= '0;
      idx     <= '0;
      par_q   <= 1'b0;
      fmt_q   <= '0;
      baud_q  <= '0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      tx_rdy  <= (state_n == ST_IDLE);
      tx_done <= done_n;
      tx_ovr  <= tx_start & ~tx_rdy;
      shreg   <= shreg_n;
      idx     <= idx_n;
      if (accept) begin
        fmt_q <= fmt_in;
        par_q <= calc_parity(tx_data, fmt_in);
      end
      // Rate is frozen for the whole frame; only idle cycles resample the code.
      if (state == ST_IDLE) begin
        baud_q <= baud;
      end
    end
  end

endmodule
